// File: rtl/rf_pkg.sv
// rf_pkg: shared state encoding, default sizes and index helpers for the register file
package rf_pkg;
   typedef enum logic {RF_CLEAR, RF_IDLE} rf_state_t;
   localparam int RF_WIDTH = 32;
   localparam int RF_NREGS = 32;
   function automatic int xp_idx(input int n);
      return n - 2;
   endfunction
   function automatic int zero_idx(input int n);
      return n - 1;
   endfunction
endpackage

// File: rtl/rf_clear_fsm.sv
// rf_clear_fsm: post-reset sweep that zeroes every stored register and holds busy meanwhile
module rf_clear_fsm import rf_pkg::*; #(
   parameter int NREGS = RF_NREGS,
   parameter int AW = $clog2(NREGS)
) (
   input  logic          clock,
   input  logic          reset_n,
   output logic          busy,
   output logic          clr_we,
   output logic [AW-1:0] clr_addr
);
   localparam logic [AW-1:0] LAST = AW'(xp_idx(NREGS));
   rf_state_t state;
   logic [AW-1:0] cnt;
   // sweep cnt over 0..NREGS-2, dropping busy on the edge that writes the last entry
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         state <= RF_CLEAR;
         cnt <= '0;
         busy <= 1'b1;
      end else if (state == RF_CLEAR) begin
         cnt <= cnt + 1'b1;
         if (cnt == LAST) begin
            state <= RF_IDLE;
            busy <= 1'b0;
         end
      end
   assign clr_we = state == RF_CLEAR;
   assign clr_addr = cnt;
endmodule

// File: rtl/regfile_bypass.sv
// regfile_bypass: 2-read/1-write register file with zero register, XP write select and optional bypass
module regfile_bypass import rf_pkg::*; #(
   parameter int WIDTH = RF_WIDTH,
   parameter int NREGS = RF_NREGS,
   parameter int BYPASS = 1,
   localparam int AW = $clog2(NREGS)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    ra,
   input  logic [AW-1:0]    rb,
   input  logic [AW-1:0]    rc,
   input  logic             ra2sel,
   input  logic             wasel,
   input  logic             werf,
   output logic [WIDTH-1:0] radata,
   output logic [WIDTH-1:0] rbdata,
   output logic             busy
);
   localparam logic [AW-1:0] ZI = AW'(zero_idx(NREGS));
   localparam logic [AW-1:0] XI = AW'(xp_idx(NREGS));
   logic [WIDTH-1:0] mem [NREGS-1];
   logic clr_we, we;
   logic [AW-1:0] clr_addr, b, w;
   rf_clear_fsm #(.NREGS(NREGS), .AW(AW)) u_clr (
      .clock(clock), .reset_n(reset_n), .busy(busy), .clr_we(clr_we), .clr_addr(clr_addr)
   );
   assign b = ra2sel ? rc : rb;
   assign w = wasel ? XI : rc;
   assign we = werf & ~busy & (w < ZI);
   // storage has no reset; the clear engine owns the write port until the sweep ends
   always_ff @(posedge clock)
      if (clr_we) mem[clr_addr] <= '0;
      else if (we) mem[w] <= wdata;
   assign radata = (busy || ra >= ZI) ? '0 : (BYPASS != 0 && we && w == ra) ? wdata : mem[ra];
   assign rbdata = (busy || b >= ZI) ? '0 : (BYPASS != 0 && we && w == b) ? wdata : mem[b];
endmodule
